// File: rtl/demux1to2_stream.sv
// Purpose: registered 1:2 stream demux, in_sel=1 steers a beat to channel A, 0 to channel B.
// Latency: one cycle from accept edge to data on the chosen channel's registered output.
// Backpressure: in_ready follows the selected slot only (free or draining this cycle); a stalled slot holds its beat.
module demux1to2_stream #(
    parameter int SIZE  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SIZE-1:0]  in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SIZE-1:0]  a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [SIZE-1:0]  b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count,
    output logic             sel_q
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t      r_a_state;
    slot_state_t      r_b_state;
    slot_state_t      w_a_state_nxt;
    slot_state_t      w_b_state_nxt;

    logic [SIZE-1:0]  r_a_data;
    logic [SIZE-1:0]  r_b_data;
    logic [CNT_W-1:0] r_a_count;
    logic [CNT_W-1:0] r_b_count;
    logic             r_sel_q;

    logic             w_a_valid;
    logic             w_b_valid;
    logic             w_a_drain;
    logic             w_b_drain;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_a_load;
    logic             w_b_load;

    assign w_a_valid = (r_a_state == SLOT_FULL);
    assign w_b_valid = (r_b_state == SLOT_FULL);

    // A slot drains when its consumer takes the held beat; ready on an empty slot is ignored.
    assign w_a_drain = w_a_valid && a_ready;
    assign w_b_drain = w_b_valid && b_ready;

    // Ready looks only at the selected slot so in_valid never feeds back into in_ready.
    assign w_in_ready = in_sel ? (!w_a_valid || a_ready) : (!w_b_valid || b_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_a_load   = w_accept && in_sel;
    assign w_b_load   = w_accept && !in_sel;

    // Next-state for both slots: fill on load, empty on drain without a reload, otherwise hold.
    always_comb begin
        w_a_state_nxt = r_a_state;
        w_b_state_nxt = r_b_state;

        case (r_a_state)
            SLOT_EMPTY: if (w_a_load) w_a_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (w_a_drain && !w_a_load) w_a_state_nxt = SLOT_EMPTY;
            default:    w_a_state_nxt = SLOT_EMPTY;
        endcase

        case (r_b_state)
            SLOT_EMPTY: if (w_b_load) w_b_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (w_b_drain && !w_b_load) w_b_state_nxt = SLOT_EMPTY;
            default:    w_b_state_nxt = SLOT_EMPTY;
        endcase
    end

    // Slot state registers; reset discards any held beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a_state <= SLOT_EMPTY;
            r_b_state <= SLOT_EMPTY;
        end else begin
            r_a_state <= w_a_state_nxt;
            r_b_state <= w_b_state_nxt;
        end
    end

    // Holding registers and last-accepted select; only the selected slot captures in_data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a_data <= '0;
            r_b_data <= '0;
            r_sel_q  <= 1'b0;
        end else begin
            if (w_a_load) r_a_data <= in_data;
            if (w_b_load) r_b_data <= in_data;
            if (w_accept) r_sel_q  <= in_sel;
        end
    end

    // Delivered-beat counters, free-running wrap with no overflow indication.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            if (w_a_drain) r_a_count <= r_a_count + CNT_W'(1);
            if (w_b_drain) r_b_count <= r_b_count + CNT_W'(1);
        end
    end

    assign in_ready = w_in_ready;
    assign a_data   = r_a_data;
    assign a_valid  = w_a_valid;
    assign b_data   = r_b_data;
    assign b_valid  = w_b_valid;
    assign a_count  = r_a_count;
    assign b_count  = r_b_count;
    assign sel_q    = r_sel_q;

endmodule
